// File: rtl/jt12_kon_seq_if.sv
// Key-on register write port between the CPU register interface and the key-on sequencer.
// Handshake: kon_we is valid, ~kon_busy is ready; a write transfers on a cycle with both high, otherwise it is dropped.
interface jt12_kon_seq_if;
    logic       kon_we;
    logic [2:0] kon_ch;
    logic [3:0] kon_op;
    logic       kon_busy;

    modport master (output kon_we, output kon_ch, output kon_op, input kon_busy);
    modport slave  (input kon_we, input kon_ch, input kon_op, output kon_busy);
endinterface

// File: rtl/jt12_kon_seq.sv
// Key-on sequencer: holds a 24-slot key state and emits per-slot keyon/keyoff edge pulses
// in slot rotation order, applying one pending CPU key-on write per operator group.
module jt12_kon_seq #(
    parameter logic [4:0] SLOT0 = 5'd0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               zero,
    jt12_kon_seq_if.slave      kon,
    output logic [4:0]         slot_II,
    output logic               keyon_II,
    output logic               keyoff_II
);

    logic [4:0]  cnt_q, cnt_d;
    logic [23:0] kstate_q, kstate_d;
    logic [2:0]  pend_ch_q, pend_ch_d;
    logic [3:0]  pend_op_q, pend_op_d;
    logic [3:0]  pend_left_q, pend_left_d;
    logic        busy_q, busy_d;
    logic [4:0]  slot_q, slot_d;
    logic        keyon_q, keyon_d;
    logic        keyoff_q, keyoff_d;

    logic [1:0]  grp;
    logic [2:0]  ch;
    logic [1:0]  opsel;
    logic        apply;
    logic        cur_key;
    logic        new_key;

    always_comb begin
        cnt_d       = cnt_q;
        kstate_d    = kstate_q;
        pend_ch_d   = pend_ch_q;
        pend_op_d   = pend_op_q;
        pend_left_d = pend_left_q;
        busy_d      = busy_q;
        grp         = 2'd0;
        ch          = cnt_q[2:0];

        if (cnt_q < 5'd6) begin
            grp = 2'd0;
            ch  = cnt_q[2:0];
        end else if (cnt_q < 5'd12) begin
            grp = 2'd1;
            ch  = 3'(cnt_q - 5'd6);
        end else if (cnt_q < 5'd18) begin
            grp = 2'd2;
            ch  = 3'(cnt_q - 5'd12);
        end else begin
            grp = 2'd3;
            ch  = 3'(cnt_q - 5'd18);
        end

        // Slot groups run S1,S3,S2,S4 while the mask is S1,S2,S3,S4: swapping grp bits maps one to the other.
        opsel   = {grp[0], grp[1]};
        apply   = busy_q && (ch == pend_ch_q) && pend_left_q[grp];
        cur_key = kstate_q[cnt_q];
        new_key = apply ? pend_op_q[opsel] : cur_key;

        kstate_d[cnt_q] = new_key;
        keyon_d         = new_key & ~cur_key;
        keyoff_d        = ~new_key & cur_key;
        slot_d          = cnt_q;

        if (apply) begin
            pend_left_d[grp] = 1'b0;
            if (pend_left_d == 4'd0) begin
                busy_d = 1'b0;
            end
        end

        // Accept uses the registered busy, so a capture never applies in its own cycle.
        if (kon.kon_we && !busy_q && (kon.kon_ch[1:0] != 2'b11)) begin
            pend_ch_d   = kon.kon_ch[2] ? ({1'b0, kon.kon_ch[1:0]} + 3'd3) : {1'b0, kon.kon_ch[1:0]};
            pend_op_d   = kon.kon_op;
            pend_left_d = 4'hF;
            busy_d      = 1'b1;
        end

        if (zero) begin
            cnt_d = SLOT0;
        end else begin
            cnt_d = (cnt_q == 5'd23) ? 5'd0 : cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= 5'd0;
            kstate_q    <= 24'd0;
            pend_ch_q   <= 3'd0;
            pend_op_q   <= 4'd0;
            pend_left_q <= 4'd0;
            busy_q      <= 1'b0;
            slot_q      <= 5'd0;
            keyon_q     <= 1'b0;
            keyoff_q    <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            kstate_q    <= kstate_d;
            pend_ch_q   <= pend_ch_d;
            pend_op_q   <= pend_op_d;
            pend_left_q <= pend_left_d;
            busy_q      <= busy_d;
            slot_q      <= slot_d;
            keyon_q     <= keyon_d;
            keyoff_q    <= keyoff_d;
        end
    end

    assign kon.kon_busy = busy_q;
    assign slot_II      = slot_q;
    assign keyon_II     = keyon_q;
    assign keyoff_II    = keyoff_q;

endmodule
